// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one Uart8 transmitter between NUM_REQ byte requesters.
// Optional packet locking (owner keeps the line until reqLast) is enabled with `define UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   reqValid,
  input  logic [8*NUM_REQ-1:0] reqData,
  input  logic [NUM_REQ-1:0]   reqLast,
  output logic [NUM_REQ-1:0]   reqReady,
  output logic                 txEn,
  output logic                 txStart,
  output logic [7:0]           txData,
  input  logic                 txBusy,
  input  logic                 txDone,
  output logic                 grantValid,
  output logic [IDW-1:0]       grantId,
  output logic [NUM_REQ-1:0]   sentDone,
  output logic                 txErr
);

`ifdef UART_TX_ARB_LOCK_EN
  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, LOCKED} stateT;
  logic lastQ, nextLast;
`else
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} stateT;
  logic unusedLast;
  assign unusedLast = ^reqLast;
`endif

  stateT                state, nextState;
  logic [IDW-1:0]       rrPtr, nextRrPtr;
  logic [7:0]           cnt, nextCnt;
  logic [NUM_REQ-1:0]   nextReqReady, nextSentDone;
  logic                 nextTxEn, nextTxStart, nextGrantValid, nextTxErr;
  logic [7:0]           nextTxData;
  logic [IDW-1:0]       nextGrantId;

  logic                 pickValid;
  logic [IDW-1:0]       pickId, cand, acceptId;
  logic                 doAccept, doComplete;
  int                   sumIdx;

  // First valid requester at or after rrPtr, wrapping modulo NUM_REQ.
  always_comb begin
    pickValid = 1'b0;
    pickId    = '0;
    cand      = '0;
    sumIdx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sumIdx = int'(rrPtr) + i;
      if (sumIdx >= NUM_REQ) sumIdx = sumIdx - NUM_REQ;
      cand = IDW'(sumIdx);
      if (!pickValid && reqValid[cand]) begin
        pickValid = 1'b1;
        pickId    = cand;
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    nextState      = state;
    nextRrPtr      = rrPtr;
    nextCnt        = cnt;
    nextReqReady   = '0;
    nextTxStart    = 1'b0;
    nextTxData     = txData;
    nextGrantValid = grantValid;
    nextGrantId    = grantId;
    nextSentDone   = '0;
    nextTxErr      = 1'b0;
    doAccept       = 1'b0;
    doComplete     = 1'b0;
    acceptId       = pickId;
`ifdef UART_TX_ARB_LOCK_EN
    nextLast       = lastQ;
`endif

    case (state)
      IDLE: begin
        if (en && pickValid) begin
          doAccept  = 1'b1;
          nextRrPtr = (pickId == IDW'(NUM_REQ - 1)) ? '0 : pickId + 1'b1;
        end
      end
      START: begin
        nextTxStart = 1'b1;
        nextCnt     = '0;
        nextState   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A very short frame can report done before busy is ever seen.
        if (txDone) begin
          doComplete = 1'b1;
        end else if (txBusy) begin
          nextState = WAIT_DONE;
        end else if (cnt == 8'(BUSY_TIMEOUT - 1)) begin
          nextTxErr      = 1'b1;
          nextGrantValid = 1'b0;
          nextState      = IDLE;
        end else begin
          nextCnt = cnt + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (txDone) doComplete = 1'b1;
      end
`ifdef UART_TX_ARB_LOCK_EN
      LOCKED: begin
        // Only the packet owner may continue; rrPtr stays where the packet's first byte left it.
        if (en && reqValid[grantId]) begin
          doAccept = 1'b1;
          acceptId = grantId;
        end
      end
`endif
      default: nextState = IDLE;
    endcase

    if (doAccept) begin
      nextReqReady[acceptId] = 1'b1;
      nextTxData             = reqData[{acceptId, 3'b000} +: 8];
      nextGrantId            = acceptId;
      nextGrantValid         = 1'b1;
      nextState              = START;
`ifdef UART_TX_ARB_LOCK_EN
      nextLast               = reqLast[acceptId];
`endif
    end

    if (doComplete) begin
      nextSentDone[grantId] = 1'b1;
      nextState             = IDLE;
      nextGrantValid        = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      if (!lastQ) begin
        nextState      = LOCKED;
        nextGrantValid = 1'b1;
      end
`endif
    end

    // Any state past IDLE keeps the transmitter enabled so a frame is never cut short.
    nextTxEn = en || (nextState != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rstN) begin
      state      <= IDLE;
      rrPtr      <= '0;
      cnt        <= '0;
      reqReady   <= '0;
      txEn       <= 1'b0;
      txStart    <= 1'b0;
      txData     <= 8'h00;
      grantValid <= 1'b0;
      grantId    <= '0;
      sentDone   <= '0;
      txErr      <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      lastQ      <= 1'b0;
`endif
    end else begin
      state      <= nextState;
      rrPtr      <= nextRrPtr;
      cnt        <= nextCnt;
      reqReady   <= nextReqReady;
      txEn       <= nextTxEn;
      txStart    <= nextTxStart;
      txData     <= nextTxData;
      grantValid <= nextGrantValid;
      grantId    <= nextGrantId;
      sentDone   <= nextSentDone;
      txErr      <= nextTxErr;
`ifdef UART_TX_ARB_LOCK_EN
      lastQ      <= nextLast;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a small behavioural Uart8 transmitter model.
// Expected grant order also covers the `UART_TX_ARB_LOCK_EN build.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ      = 4;
  localparam int BUSY_TIMEOUT = 16;
  localparam int FRAME        = 8;

  typedef struct packed {
    logic [3:0] id;
    logic [7:0] data;
    logic       last;
  } itemT;

  typedef struct packed {
    logic [3:0] id;
    logic [7:0] data;
    logic       held;
  } doneT;

  logic                 clk, rstN, en;
  logic [NUM_REQ-1:0]   reqValid, reqLast, reqReady, sentDone;
  logic [8*NUM_REQ-1:0] reqData;
  logic                 txEn, txStart, txBusy, txDone, grantValid, txErr;
  logic [7:0]           txData;
  logic [1:0]           grantId;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk), .rstN(rstN), .en(en),
    .reqValid(reqValid), .reqData(reqData), .reqLast(reqLast), .reqReady(reqReady),
    .txEn(txEn), .txStart(txStart), .txData(txData), .txBusy(txBusy), .txDone(txDone),
    .grantValid(grantValid), .grantId(grantId), .sentDone(sentDone), .txErr(txErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   nCompared = 0, nMismatched = 0;
  int   cycle = 0, acceptCycle = -10, startCycle = -10, doneCycle = -10;
  itemT pend[$];
  itemT expQ[$];
  doneT doneQ[$];
  bit   errPending = 0, noBusy = 0, mActive = 0, mTrack = 0;
  int   mCnt = 0;
  logic [7:0] mData = '0, lineByte = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic addReq(input int id, input logic [7:0] data, input bit last);
    pend.push_back({4'(id), data, last});
  endtask

  task automatic pushExp(input int id, input logic [7:0] data);
    expQ.push_back({4'(id), data, 1'b0});
  endtask

  task automatic monitorStep();
    itemT e;
    int   gi;
    bit   lastOfByte, held;
    doneT d;
    if (reqReady != '0) begin
      if (expQ.size() == 0) begin
        check("unexpReady", 32'(reqReady), 32'd0);
      end else begin
        e = expQ.pop_front();
        check("grantOneHot", 32'(reqReady), 32'd1 << e.id);
        check("grantId", 32'(grantId), 32'(e.id));
        check("grantData", 32'(txData), 32'(e.data));
        check("grantValid", 32'(grantValid), 32'd1);
        gi = 0;
        for (int i = 0; i < NUM_REQ; i++) if (reqReady[i]) gi = i;
        lastOfByte = 1'b1;
        for (int k = 0; k < pend.size(); k++) begin
          if (pend[k].id == 4'(gi)) begin
            lastOfByte = pend[k].last;
            pend.delete(k);
            break;
          end
        end
`ifdef UART_TX_ARB_LOCK_EN
        held = !lastOfByte;
`else
        held = 1'b0;
`endif
        if (noBusy) errPending = 1'b1;
        else begin
          d = {e.id, e.data, held};
          doneQ.push_back(d);
        end
      end
      acceptCycle = cycle;
    end
    if (txStart) begin
      check("startLatency", 32'(cycle), 32'(acceptCycle + 1));
      startCycle = cycle;
    end
    if (txErr) begin
      check("errExpected", 32'(errPending), 32'd1);
      check("errLatency", 32'(cycle - startCycle), 32'(BUSY_TIMEOUT));
      errPending = 1'b0;
    end
    if (sentDone != '0) begin
      if (doneQ.size() == 0) begin
        check("unexpDone", 32'(sentDone), 32'd0);
      end else begin
        d = doneQ.pop_front();
        check("doneOneHot", 32'(sentDone), 32'd1 << d.id);
        check("lineByte", 32'(lineByte), 32'(d.data));
        check("doneLatency", 32'(cycle), 32'(doneCycle + 1));
        check("grantAfterDone", 32'(grantValid), 32'(d.held));
      end
    end
  endtask

  // Uart8 stand-in: busy two cycles after start, done pulse FRAME cycles later.
  task automatic modelStep();
    txDone = 1'b0;
    if (mActive) begin
      mCnt++;
      if (mCnt == 2) txBusy = 1'b1;
      if (mCnt == 2 + FRAME) begin
        if (mTrack) check("txHold", 32'(txData), 32'(mData));
        txBusy    = 1'b0;
        txDone    = 1'b1;
        lineByte  = mData;
        doneCycle = cycle;
        mActive   = 1'b0;
      end
    end else if (txStart && !noBusy) begin
      mActive = 1'b1;
      mTrack  = 1'b1;
      mCnt    = 0;
      mData   = txData;
    end
  endtask

  task automatic driveReqs();
    bit found;
    for (int i = 0; i < NUM_REQ; i++) begin
      found = 1'b0;
      reqValid[i] = 1'b0;
      reqLast[i]  = 1'b0;
      reqData[8*i +: 8] = 8'h00;
      for (int k = 0; k < pend.size(); k++) begin
        if (!found && pend[k].id == 4'(i)) begin
          found = 1'b1;
          reqValid[i] = 1'b1;
          reqLast[i]  = pend[k].last;
          reqData[8*i +: 8] = pend[k].data;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    cycle++;
    monitorStep();
    modelStep();
    driveReqs();
  end

  task automatic checkResetVals(input string tag);
    check({tag, ".reqReady"}, 32'(reqReady), 32'd0);
    check({tag, ".txEn"}, 32'(txEn), 32'd0);
    check({tag, ".txStart"}, 32'(txStart), 32'd0);
    check({tag, ".txData"}, 32'(txData), 32'd0);
    check({tag, ".grantValid"}, 32'(grantValid), 32'd0);
    check({tag, ".grantId"}, 32'(grantId), 32'd0);
    check({tag, ".sentDone"}, 32'(sentDone), 32'd0);
    check({tag, ".txErr"}, 32'(txErr), 32'd0);
  endtask

  task automatic waitQuiet(input string tag);
    int n = 0;
    while (!(expQ.size() == 0 && doneQ.size() == 0 && pend.size() == 0 && !errPending &&
             !mActive && !grantValid && !txBusy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".quiet"}, 32'(n < 500), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    rstN = 1'b0; en = 1'b0;
    reqValid = '0; reqData = '0; reqLast = '0;
    txBusy = 1'b0; txDone = 1'b0;
    repeat (3) @(negedge clk);
    checkResetVals("rst");
    rstN = 1'b1; en = 1'b1;

    // Single requester
    addReq(0, 8'h56, 1'b1); pushExp(0, 8'h56);
    waitQuiet("single");

    // Fresh rrPtr, all four requesters contending
    rstN = 1'b0; @(negedge clk); rstN = 1'b1;
    addReq(0, 8'h11, 1'b1); addReq(1, 8'h22, 1'b1); addReq(2, 8'h33, 1'b1);
    addReq(3, 8'h44, 1'b1); addReq(0, 8'h55, 1'b1);
    pushExp(0, 8'h11); pushExp(1, 8'h22); pushExp(2, 8'h33); pushExp(3, 8'h44); pushExp(0, 8'h55);
    waitQuiet("rr4");

    // Transmitter never goes busy: rrPtr is at 1
    noBusy = 1'b1;
    addReq(1, 8'hA1, 1'b1); addReq(2, 8'hA2, 1'b1);
    pushExp(1, 8'hA1); pushExp(2, 8'hA2);
    n = 0;
    while (!txErr && n < 100) begin @(negedge clk); n++; end
    check("errSeen", 32'(n < 100), 32'd1);
    noBusy = 1'b0;
    waitQuiet("timeout");

    // Reset while in WAIT_DONE; rrPtr is at 3
    addReq(3, 8'h77, 1'b1); pushExp(3, 8'h77);
    n = 0;
    while (!txBusy && n < 100) begin @(negedge clk); n++; end
    check("busySeen", 32'(n < 100), 32'd1);
    repeat (2) @(negedge clk);
    rstN = 1'b0; mTrack = 1'b0;
    @(negedge clk);
    checkResetVals("midRst");
    rstN = 1'b1;
    doneQ.delete();
    n = 0;
    while (mActive && n < 100) begin @(negedge clk); n++; end
    check("staleDone", 32'(n < 100), 32'd1);
    repeat (4) @(negedge clk);
    addReq(2, 8'h88, 1'b1); addReq(0, 8'h99, 1'b1);
    pushExp(0, 8'h99); pushExp(2, 8'h88);
    waitQuiet("afterRst");

    // Packet from requester 2 while requester 1 waits; leave rrPtr at 2 first
    addReq(1, 8'hB0, 1'b1); pushExp(1, 8'hB0);
    waitQuiet("prePkt");
    addReq(2, 8'hC0, 1'b0); addReq(2, 8'hC1, 1'b0); addReq(2, 8'hC2, 1'b1);
    addReq(1, 8'hD0, 1'b1);
`ifdef UART_TX_ARB_LOCK_EN
    pushExp(2, 8'hC0); pushExp(2, 8'hC1); pushExp(2, 8'hC2); pushExp(1, 8'hD0);
`else
    pushExp(2, 8'hC0); pushExp(1, 8'hD0); pushExp(2, 8'hC1); pushExp(2, 8'hC2);
`endif
    waitQuiet("packet");

    // en dropped mid-frame
    addReq(0, 8'hE0, 1'b1); pushExp(0, 8'hE0);
    n = 0;
    while (!txBusy && n < 100) begin @(negedge clk); n++; end
    check("busySeen2", 32'(n < 100), 32'd1);
    en = 1'b0;
    addReq(3, 8'hE3, 1'b1);
    repeat (3) begin @(negedge clk); check("txEnHold", 32'(txEn), 32'd1); end
    n = 0;
    while (doneQ.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("doneSeen", 32'(n < 100), 32'd1);
    @(negedge clk);
    check("txEnDrop", 32'(txEn), 32'd0);
    check("noGrant", 32'(grantValid), 32'd0);
    repeat (20) @(negedge clk);
    en = 1'b1;
    pushExp(3, 8'hE3);
    waitQuiet("reEnable");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Transmit-side controller for `Uart8`: shares the single UART transmitter between `NUM_REQ` byte requesters using round-robin arbitration. It sequences each byte through the `Uart8` tx handshake and holds the byte stable while it is on the line. It reports completion back to the owning requester and detects a transmitter that never starts. It sits between client logic and the `txStart`/`in`/`txBusy`/`txDone` pins of `Uart8`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8; `IDW` = max(1, clog2(`NUM_REQ`)).
- `BUSY_TIMEOUT`, 16: cycles allowed between `txStart` and `txBusy`/`txDone`, 2..255.
- `clk`  in  1  single clock, rising edge.
- `rstN`  in  1  synchronous, active-low reset.
- `en`  in  1  permits new grants.
- `reqValid`  in  NUM_REQ  requester i has a byte.
- `reqData`  in  8*NUM_REQ  byte of requester i at [8i+7:8i].
- `reqLast`  in  NUM_REQ  byte ends a packet; used only under `UART_TX_ARB_LOCK_EN`.
- `reqReady`  out  NUM_REQ  one-cycle accept pulse, one-hot.
- `txEn`  out  1  to `Uart8` txEn.
- `txStart`  out  1  one-cycle start pulse to `Uart8`.
- `txData`  out  8  to `Uart8` `in`, stable from accept to done.
- `txBusy`  in  1  from `Uart8`.
- `txDone`  in  1  from `Uart8`, one-cycle pulse after stop bit.
- `grantValid`  out  1  a byte is owned and in flight.
- `grantId`  out  IDW  owner index.
- `sentDone`  out  NUM_REQ  one-cycle pulse to owner when its byte completes.
- `txErr`  out  1  one-cycle pulse on busy timeout.

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE (plus LOCKED under the macro).
- IDLE: if `en` and any `reqValid`, pick the first valid index at or after `rrPtr`, wrapping modulo `NUM_REQ`. Assert that `reqReady` bit. Latch `reqData` slice into `txData`. Set `grantId` and `grantValid`. Set `rrPtr` = grant+1 mod `NUM_REQ`. Go to START.
- START: `txStart`=1 for exactly one cycle. Clear the timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY:
  - `txBusy`=1 -> WAIT_DONE.
  - `txDone`=1 -> treat as completion, same as WAIT_DONE.
  - Counter reaches `BUSY_TIMEOUT` -> pulse `txErr`, clear `grantValid`, go to IDLE, no `sentDone`.
- WAIT_DONE: on `txDone`, pulse `sentDone[grantId]`, clear `grantValid`, go to IDLE. There is no timeout in this state.
- `txEn` = `en` OR (state != IDLE). Deasserting `en` mid-byte never truncates a frame.
- Simultaneous `reqValid`: exactly one is accepted per grant; the others stay pending with no loss.
- Reset mid-operation: state IDLE, `rrPtr`=0. All outputs go to reset values on the next edge. A byte already inside `Uart8` is not tracked and produces no `sentDone`. `txDone` in IDLE is ignored.

## Timing
- Reset values: `reqReady`=0, `txEn`=0, `txStart`=0, `txData`=8'h00, `grantValid`=0, `grantId`=0, `sentDone`=0, `txErr`=0.
- Accept cycle N (IDLE, `reqReady` high). Cycle N+1: `txStart` high, `txData` already valid. Cycle N+2: WAIT_BUSY.
- Completion: `sentDone` is high in the cycle after `txDone` is sampled. The next accept can occur in the following cycle, giving a 2-cycle gap from `txDone` to the next `reqReady`.
- Timeout: `txErr` asserts `BUSY_TIMEOUT` cycles after the START cycle.
- All outputs are registered. Requesters must hold `reqValid`/`reqData` until `reqReady`.

## Configuration
- `UART_TX_ARB_LOCK_EN` defined:
  - After `txDone` for a byte whose latched `reqLast` was 0, go to LOCKED instead of IDLE. `grantValid`/`grantId` stay held.
  - LOCKED accepts only the owner's `reqValid`, with the same accept timing as IDLE. Other requesters are ignored.
  - Lock is released after the byte carrying `reqLast`=1 completes, or on `txErr`. `rrPtr` is not advanced for in-packet bytes.
- `UART_TX_ARB_LOCK_EN` undefined: `reqLast` is ignored, LOCKED does not exist, and arbitration runs every byte.

## Test plan
- Single requester 0 with byte 8'h56, `Uart8` at 9600 baud from 12 MHz: `reqReady[0]` pulse, then `txStart` one cycle later, `txData`=8'h56 until `sentDone[0]`. The line shows 0x56 LSB-first.
- All 4 requesters valid with 8'h11/22/33/44 held: grant order 0,1,2,3, then 0 again. Each `sentDone` pulses once per byte.
- `txBusy` tied 0 with `BUSY_TIMEOUT`=16: `txErr` pulses 16 cycles after `txStart`, no `sentDone`, arbiter returns to IDLE and serves the next requester.
- `rstN` low for one cycle during WAIT_DONE: all outputs return to reset values. The next grant goes to requester 0 (`rrPtr`=0), and a stale `txDone` is ignored.
- With `UART_TX_ARB_LOCK_EN`, requester 2 sends a 3-byte packet (`reqLast`=0,0,1) while requester 1 is valid: bytes 2,2,2 go out before requester 1 is granted. Without the macro, the order is 2,1,2,...
- `en` dropped mid-frame: the frame completes, `txEn` stays high until `sentDone`, then drops, and no new grant is made.
